gf2m163_reduce_seq: RTL and testbench
=====================================

# gf2m163_reduce_seq

Sequential modular-reduction stage for the 163-bit OBS multiplier. It consumes the 325-bit unreduced GF(2)[x] product assembled by the overlap tree and folds it modulo the NIST B-163 pentanomial f(x) = x^163 + x^7 + x^6 + x^3 + 1. The result is a 163-bit field element. The block sits directly downstream of the top-level overlap stage, with valid/ready handshakes on both sides.

## Interface
- M, 163, field degree; input width is 2M-1, output width is M.
- TAPS, 8'hC9, low-order terms of f(x) as a bit mask (bits 7, 6, 3, 0 set).
- NUM_FOLDS, 2, fold iterations per operand. 2 is sufficient for B-163.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data holds a product to be reduced.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  2M-1  unreduced product; bit i is the coefficient of x^i.
- out_valid  out  1  out_data holds a reduced result.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  M  reduced product (acc[M-1:0]).

## Operation
- State machine: IDLE, FOLD, OUT. Registers: acc[2M-2:0] and fold counter cnt (width clog2(NUM_FOLDS+1)).
- Reset (asynchronous, rst_n=0): state=IDLE, acc=0, cnt=0, so in_ready=1, out_valid=0, out_data=0.
- Accept occurs when in_valid & in_ready at an edge. On accept: acc←in_data, cnt←0, state←FOLD.
- FOLD, on each edge:
  - h = acc[2M-2:M], l = acc[M-1:0].
  - acc ← zero-extend(l) XOR the XOR over every set bit t of TAPS of (zero-extend(h) << t), truncated to 2M-1 bits.
  - cnt←cnt+1.
  - When cnt reaches NUM_FOLDS-1, state←OUT.
- Width argument: after fold 1 the degree is ≤168. After fold 2 the degree is ≤162, so acc[2M-2:M]==0 in OUT. This is an assertion target.
- OUT: out_valid=1 and out_data=acc[M-1:0]. Both stay stable while out_ready=0.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
  - Handing off a result and accepting the next operand in the same cycle is legal. The next state is FOLD with the new acc.
- OUT & out_ready & !in_valid → IDLE.
- in_data is ignored when in_ready=0. in_valid may be withdrawn freely.
- rst_n asserted mid-FOLD or in OUT discards the operand. No output is produced for it.

## Timing
- Latency: accept at edge E0, folds at E1 and E2, out_valid=1 in the cycle following E2. Total latency is NUM_FOLDS edges after accept.
- Throughput: one result per NUM_FOLDS+1 cycles with back-to-back operands and out_ready held high.
- out_valid, out_data, acc and state are all registered.
- in_ready has a combinational path from out_ready only.
- No combinational path from in_data to any output.

## Structure
- Package gf2m163_pkg holds:
  - M, TAPS and NUM_FOLDS defaults;
  - the state enum (IDLE, FOLD, OUT);
  - a constant function computing the required fold count, for an elaboration-time check that NUM_FOLDS is at least that value.
- Sub-module gf2m_fold: purely combinational, one fold step. Parameters M and TAPS, input acc[2M-2:0], output acc_next[2M-2:0].
  - Instantiated once; the FSM reuses it on every FOLD cycle.
  - Reused later by a fully unrolled pipelined variant.

## Test plan
- Reset then idle: after rst_n release, in_ready=1, out_valid=0, out_data=0. Assert rst_n mid-FOLD → out_valid stays 0 and in_ready=1 on the next cycle.
- Single-term x^163 (in_data bit 163 only) → out_data = 163'hC9, with out_valid exactly 2 cycles after accept.
- Single-term x^324 (bit 324 only) → out_data bits {161, 12, 10, 5, 1} set, all others 0.
- Low-only inputs:
  - in_data = 325'h1 → out_data = 1;
  - in_data with bits [162:0] all ones and the upper bits zero → out_data all ones (pass-through).
- Backpressure: hold out_ready=0 for 5 cycles → out_valid and out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 → same-cycle handoff, and the second result appears 2 cycles later.
- Random regression: 10k random 325-bit products, out_ready randomly throttled. Check against a software polynomial-mod model, with an assertion that acc[324:163]==0 whenever out_valid=1.

Source files
------------

// File: rtl/gf2m163_pkg.sv
// Shared constants, FSM state type and fold-count helper for the B-163 reduction stage.
package gf2m163_pkg;

  localparam int         M_DEF         = 163;
  localparam logic [7:0] TAPS_DEF      = 8'hC9;
  localparam int         NUM_FOLDS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    OUT
  } state_t;

  function automatic int tap_degree(input logic [7:0] taps);
    int d;
    d = 0;
    for (int t = 0; t < 8; t++) begin
      if (taps[t]) d = t;
    end
    return d;
  endfunction

  // Each fold maps degree d to (d - m + k); count folds until the degree drops below m.
  function automatic int required_folds(input int m, input logic [7:0] taps);
    int deg;
    int n;
    int k;
    deg = 2 * m - 2;
    n   = 0;
    k   = tap_degree(taps);
    while (deg >= m && n < 64) begin
      deg = deg - m + k;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/gf2m_fold.sv
// One combinational fold step: acc mod f(x) partially reduced by folding the high half onto the taps.
module gf2m_fold
  import gf2m163_pkg::*;
#(
  parameter int         M    = M_DEF,
  parameter logic [7:0] TAPS = TAPS_DEF
) (
  input  logic [2*M-2:0] acc,
  output logic [2*M-2:0] acc_next
);

  localparam int W = 2 * M - 1;

  logic [W-1:0] h_ext;
  logic [W-1:0] part [0:8];

  assign h_ext   = {{M{1'b0}}, acc[W-1:M]};
  assign part[0] = {{(M-1){1'b0}}, acc[M-1:0]};

  // x^M == TAPS(x), so every set tap contributes a shifted copy of the high half.
  for (genvar gi = 0; gi < 8; gi++) begin : g_tap
    if (TAPS[gi]) begin : g_on
      assign part[gi+1] = part[gi] ^ (h_ext << gi);
    end else begin : g_off
      assign part[gi+1] = part[gi];
    end
  end

  assign acc_next = part[8];

endmodule

// File: rtl/gf2m163_reduce_seq.sv
// Sequential B-163 reduction: accepts a 325-bit product, folds it NUM_FOLDS times, emits a 163-bit element.
module gf2m163_reduce_seq
  import gf2m163_pkg::*;
#(
  parameter int         M         = M_DEF,
  parameter logic [7:0] TAPS      = TAPS_DEF,
  parameter int         NUM_FOLDS = NUM_FOLDS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-2:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data
);

  localparam int                W         = 2 * M - 1;
  localparam int                CNT_W     = $clog2(NUM_FOLDS + 1);
  localparam logic [CNT_W-1:0]  LAST_FOLD = CNT_W'(NUM_FOLDS - 1);

  if (NUM_FOLDS < required_folds(M, TAPS)) begin : g_fold_check
    $error("NUM_FOLDS too small to fully reduce modulo f(x)");
  end

  state_t           state_reg, state_next;
  logic [W-1:0]     acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [W-1:0]     fold_out;

  gf2m_fold #(
    .M    (M),
    .TAPS (TAPS)
  ) u_fold (
    .acc      (acc_reg),
    .acc_next (fold_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          acc_next   = in_data;
          cnt_next   = '0;
          state_next = FOLD;
        end
      end
      FOLD: begin
        acc_next = fold_out;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_FOLD) state_next = OUT;
      end
      OUT: begin
        // Result handoff and next accept may share a cycle.
        if (out_ready) begin
          if (in_valid) begin
            acc_next   = in_data;
            cnt_next   = '0;
            state_next = FOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE) | ((state_reg == OUT) & out_ready);
    out_valid = (state_reg == OUT);
    out_data  = acc_reg[M-1:0];
  end

  a_upper_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == OUT) |-> (acc_reg[W-1:M] == '0));

endmodule

// File: tb/tb_gf2m163_reduce_seq.sv
// Scoreboard bench for gf2m163_reduce_seq: directed corner products plus throttled random regression.
module tb_gf2m163_reduce_seq;

  localparam int M = 163;
  localparam int W = 2 * M - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [M-1:0] out_data;

  logic ready_force = 1'b1;
  logic rand_ready  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [M-1:0] exp_q [$];

  logic         prev_stall = 1'b0;
  logic [M-1:0] prev_data  = '0;

  gf2m163_reduce_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 4) != 0) : ready_force;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bitwise long division by f(x), independent of the fold structure.
  function automatic logic [M-1:0] ref_mod(input logic [W-1:0] p);
    logic [W-1:0] r;
    r = p;
    for (int i = W - 1; i >= M; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        r[i-M +: 8] = r[i-M +: 8] ^ 8'hC9;
      end
    end
    return r[M-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", W'(out_valid), W'(1'b1));
        check_eq("stall_data", W'(out_data), W'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", W'(1'b1), W'(1'b0));
        else check_eq("out_data", W'(out_data), W'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [M-1:0] e);
    bit done;
    int k;
    done = 0;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done && k < 100) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
    if (!done) check_eq("send_timeout", W'(1'b0), W'(1'b1));
  endtask

  // Presents an operand that must be accepted now, then checks out_valid rises exactly 2 edges later.
  task automatic send_timed(input string tag, input logic [W-1:0] d, input logic [M-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, W'(in_ready), W'(1'b1));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat0"}, W'(out_valid), W'(1'b0));
    @(negedge clk);
    check_eq({tag, "_lat1"}, W'(out_valid), W'(1'b0));
    @(negedge clk);
    check_eq({tag, "_lat2"}, W'(out_valid), W'(1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (exp_q.size() != 0) check_eq("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    logic [W-1:0] d;
    logic [351:0] wide;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", W'(in_ready), W'(1'b1));
    check_eq("rst_out_valid", W'(out_valid), W'(1'b0));
    check_eq("rst_out_data", W'(out_data), W'(0));
    @(posedge clk);
    #1;

    d = '0; d[163] = 1'b1;
    send_timed("x163", d, 163'hC9);
    drain();

    d = '0; d[324] = 1'b1;
    begin
      logic [M-1:0] e;
      e = '0;
      e[161] = 1'b1; e[12] = 1'b1; e[10] = 1'b1; e[5] = 1'b1; e[1] = 1'b1;
      send(d, e);
    end
    d = W'(1);
    send(d, 163'h1);
    d = {{(M-1){1'b0}}, {M{1'b1}}};
    send(d, {M{1'b1}});
    drain();

    // Backpressure then same-cycle handoff.
    ready_force = 1'b0;
    d = '0; d[200] = 1'b1; d[3] = 1'b1;
    send(d, ref_mod(d));
    for (int k = 0; k < 20 && !out_valid; k++) @(posedge clk);
    #1;
    check_eq("bp_out_valid", W'(out_valid), W'(1'b1));
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_in_ready", W'(in_ready), W'(1'b0));
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    d = '0; d[300] = 1'b1; d[170] = 1'b1; d[7] = 1'b1;
    send_timed("handoff", d, ref_mod(d));
    drain();

    // Reset mid-FOLD discards the operand.
    d = '0; d[250] = 1'b1;
    send(d, ref_mod(d));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_fold_out_valid", W'(out_valid), W'(1'b0));
    check_eq("rst_fold_in_ready", W'(in_ready), W'(1'b1));
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_out_valid", W'(out_valid), W'(1'b0));
    check_eq("post_rst_in_ready", W'(in_ready), W'(1'b1));
    @(posedge clk);
    #1;

    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 11; k++) wide[k*32 +: 32] = $urandom;
      d = wide[W-1:0];
      send(d, ref_mod(d));
      if ($urandom_range(0, 15) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check_eq("leftover", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
